instr_encoder: RTL and testbench
================================

# instr_encoder

Packs symbolic instruction descriptors (kind, register numbers, immediate, jump target) into 32-bit MIPS words. It writes them sequentially into instruction memory through a single write port, producing the same opcodes and functs that the control decoder consumes. It sits between the testbench or program-loader front end and the instruction memory, and is used to load programs before the CPU is released from reset.

## Interface
Parameters:
- ADDR_W, 8: log2 of program capacity in words (DEPTH = 2^ADDR_W).
- BASE_ADDR, 32'h0: byte address of the first written word.

Ports:
- clk_i  in  1: clock; all state updates on the rising edge.
- rst_i  in  1: reset, asynchronous, active-low.
- start_i  in  1: begin a new program; clears the word count.
- valid_i  in  1: descriptor valid.
- ready_o  out  1: descriptor accepted this cycle when valid_i & ready_o.
- kind_i  in  4: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 ADDI, 6 LW, 7 SW, 8 BEQ, 9 BNE, 10 J, 11 JAL, 12 NOP; 13-15 illegal.
- rs_i, rt_i, rd_i  in  5 each: register fields.
- imm_i  in  16: I-type immediate, inserted verbatim.
- target_i  in  26: J-type word target.
- last_i  in  1: this descriptor ends the program.
- imem_we_o  out  1: instruction-memory write strobe.
- imem_addr_o  out  32: byte address, BASE_ADDR + 4*index.
- imem_data_o  out  32: encoded word.
- count_o  out  ADDR_W+1: number of words written since start.
- done_o  out  1: high in DONE.
- err_o  out  1: high in ERR.

## Operation
- The FSM has four states: IDLE, RUN, DONE, ERR. Reset enters IDLE.
- start_i in any state moves to RUN on the next edge, with count 0. start_i has priority over the handshake.
- ready_o = (state==RUN) & !start_i & (count < DEPTH).
- RUN, on an accepted legal descriptor: register the word, address and strobe; count increments; if last_i is set, go to DONE.
- RUN, on an accepted illegal kind: go to ERR. No write occurs and count is unchanged.
- RUN, accepted legal descriptor that makes count == DEPTH without last_i: the word is written, then the FSM goes to ERR (overflow).
- DONE and ERR hold until start_i; ready_o is 0 in both.
- Encoding:
  - R-type: op 0, shamt 0, funct ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2A.
  - ADDI op 0x08, LW 0x23, SW 0x2B, BEQ 0x04, BNE 0x05: {op, rs, rt, imm}.
  - J op 0x02, JAL 0x03: {op, target}.
  - NOP is 32'h0 and is written like any word.
  - Fields not used by a kind are ignored.

## Timing
- Reset values:
  - state IDLE; count_o 0; imem_we_o 0; imem_addr_o 0; imem_data_o 0; done_o 0; err_o 0.
  - ready_o is 0 because state is IDLE.
- Write latency is 1 cycle: a descriptor accepted at edge N drives imem_we_o high for exactly the cycle after edge N, with address and data stable in that cycle.
- imem_we_o is a single-cycle pulse per accepted legal descriptor. Back-to-back accepts give consecutive strobes and consecutive addresses. Throughput is 1 word per cycle.
- count_o updates at the same edge that asserts imem_we_o.
- done_o and err_o assert at the same edge as the final or faulting strobe, or for an illegal kind at the edge after acceptance.
- start_i asserted in the cycle carrying a pending strobe: that write completes, and the next accept writes BASE_ADDR.
- rst_i asserted mid-program: all outputs clear immediately (asynchronously). A pending write is dropped.
- imem_addr_o wraps modulo 2^32 and is not otherwise checked.

## Structure
- Shared package holds:
  - kind codes (4-bit enum);
  - opcode constants OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL;
  - funct constants;
  - FSM state encoding.
- One combinational sub-module, instr_field_pack: maps kind and fields to {word, illegal}. The top level holds the FSM, counter and output registers.

## Test plan
- Reset, start, then ADD rs=1 rt=2 rd=3 with last -> one strobe, addr 0x0, data 0x00221820, count 1, done_o 1.
- Start, then back-to-back ADDI rs=1 rt=2 imm=5, LW rs=0 rt=4 imm=8, BEQ rs=1 rt=2 imm=0xFFFF, J target=0x10 (last):
  - data 0x20220005, 0x8C040008, 0x1022FFFF, 0x08000010;
  - addr 0x0, 0x4, 0x8, 0xC on consecutive cycles;
  - done_o 1.
- kind_i=14 in RUN -> no strobe, err_o 1, ready_o 0; a later start_i recovers to RUN with count 0.
- ADDR_W=2: four legal descriptors without last -> four writes, then err_o 1. ready_o is 0 with count 4.
- valid_i held high with start_i pulsed mid-stream -> no accept while start_i is high; the next word lands at BASE_ADDR.
- rst_i low during a stream -> imem_we_o, count_o, done_o and err_o go to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// Shared encodings for the instruction encoder: descriptor kinds, MIPS opcodes/functs,
// FSM states and small word-packing helpers.
package instr_encoder_pkg;

    typedef enum logic [3:0] {
        KIND_ADD  = 4'd0,
        KIND_SUB  = 4'd1,
        KIND_AND  = 4'd2,
        KIND_OR   = 4'd3,
        KIND_SLT  = 4'd4,
        KIND_ADDI = 4'd5,
        KIND_LW   = 4'd6,
        KIND_SW   = 4'd7,
        KIND_BEQ  = 4'd8,
        KIND_BNE  = 4'd9,
        KIND_J    = 4'd10,
        KIND_JAL  = 4'd11,
        KIND_NOP  = 4'd12
    } kind_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    function automatic logic [31:0] pack_r(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [5:0] funct);
        return {OP_RTYPE, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [31:0] pack_i(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] pack_j(input logic [5:0] op, input logic [25:0] target);
        return {op, target};
    endfunction

endpackage

// File: rtl/instr_encoder_field_pack.sv
// Combinational mapping from a symbolic descriptor to a 32-bit MIPS word.
// Codes outside the kind table raise illegal and yield a zero word.
module instr_field_pack
    import instr_encoder_pkg::*;
(
    input  logic [3:0]  i_kind,
    input  logic [4:0]  i_rs,
    input  logic [4:0]  i_rt,
    input  logic [4:0]  i_rd,
    input  logic [15:0] i_imm,
    input  logic [25:0] i_target,
    output logic [31:0] o_word,
    output logic        o_illegal
);

    always_comb begin
        o_word    = 32'h0;
        o_illegal = 1'b0;
        case (i_kind)
            KIND_ADD:  o_word = pack_r(i_rs, i_rt, i_rd, FUNCT_ADD);
            KIND_SUB:  o_word = pack_r(i_rs, i_rt, i_rd, FUNCT_SUB);
            KIND_AND:  o_word = pack_r(i_rs, i_rt, i_rd, FUNCT_AND);
            KIND_OR:   o_word = pack_r(i_rs, i_rt, i_rd, FUNCT_OR);
            KIND_SLT:  o_word = pack_r(i_rs, i_rt, i_rd, FUNCT_SLT);
            KIND_ADDI: o_word = pack_i(OP_ADDI, i_rs, i_rt, i_imm);
            KIND_LW:   o_word = pack_i(OP_LW, i_rs, i_rt, i_imm);
            KIND_SW:   o_word = pack_i(OP_SW, i_rs, i_rt, i_imm);
            KIND_BEQ:  o_word = pack_i(OP_BEQ, i_rs, i_rt, i_imm);
            KIND_BNE:  o_word = pack_i(OP_BNE, i_rs, i_rt, i_imm);
            KIND_J:    o_word = pack_j(OP_J, i_target);
            KIND_JAL:  o_word = pack_j(OP_JAL, i_target);
            KIND_NOP:  o_word = 32'h0;
            default:   o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: accepts descriptors, encodes them and writes them sequentially
// into instruction memory with a one-cycle registered write port.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [3:0]        kind_i,
    input  logic [4:0]        rs_i,
    input  logic [4:0]        rt_i,
    input  logic [4:0]        rd_i,
    input  logic [15:0]       imm_i,
    input  logic [25:0]       target_i,
    input  logic              last_i,
    output logic              imem_we_o,
    output logic [31:0]       imem_addr_o,
    output logic [31:0]       imem_data_o,
    output logic [ADDR_W:0]   count_o,
    output logic              done_o,
    output logic              err_o
);

    localparam logic [ADDR_W:0] DEPTH   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_e            r_state;
    state_e            w_state_nxt;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W:0]   w_count_nxt;
    logic              r_we_p1;
    logic [31:0]       r_addr_p1;
    logic [31:0]       r_data_p1;

    logic [31:0]       w_word;
    logic              w_illegal;
    logic              w_ready;
    logic              w_accept;
    logic              w_write;
    logic [31:0]       w_addr;

    instr_field_pack u_pack (
        .i_kind    (kind_i),
        .i_rs      (rs_i),
        .i_rt      (rt_i),
        .i_rd      (rd_i),
        .i_imm     (imm_i),
        .i_target  (target_i),
        .o_word    (w_word),
        .o_illegal (w_illegal)
    );

    assign w_ready  = (r_state == ST_RUN) && !start_i && (r_count < DEPTH);
    assign w_accept = valid_i && w_ready;
    assign w_addr   = BASE_ADDR + {{(32-ADDR_W-3){1'b0}}, r_count, 2'b00};

    // start_i outranks the handshake; ready_o is already low while it is high
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_write     = 1'b0;
        if (start_i) begin
            w_state_nxt = ST_RUN;
            w_count_nxt = '0;
        end else if (w_accept) begin
            if (w_illegal) begin
                w_state_nxt = ST_ERR;
            end else begin
                w_write     = 1'b1;
                w_count_nxt = r_count + CNT_ONE;
                if (last_i) begin
                    w_state_nxt = ST_DONE;
                end else if (w_count_nxt == DEPTH) begin
                    w_state_nxt = ST_ERR;
                end
            end
        end
    end

    // stage p1: registered write port, one cycle after acceptance
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_we_p1   <= 1'b0;
            r_addr_p1 <= 32'h0;
            r_data_p1 <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_we_p1 <= w_write;
            if (w_write) begin
                r_addr_p1 <= w_addr;
                r_data_p1 <= w_word;
            end
        end
    end

    assign ready_o     = w_ready;
    assign imem_we_o   = r_we_p1;
    assign imem_addr_o = r_addr_p1;
    assign imem_data_o = r_data_p1;
    assign count_o     = r_count;
    assign done_o      = (r_state == ST_DONE);
    assign err_o       = (r_state == ST_ERR);

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: a default-size instance and a 4-word instance
// share one stimulus stream and are each compared against a behavioural program-loader model.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, valid, last;
    logic [3:0]  kind;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] tgt;

    logic        ready_a, we_a, done_a, err_a;
    logic [31:0] addr_a, data_a;
    logic [8:0]  cnt_a;
    logic        ready_b, we_b, done_b, err_b;
    logic [31:0] addr_b, data_b;
    logic [2:0]  cnt_b;

    int n_checks = 0;
    int n_fail   = 0;

    // model state per instance: 0 idle, 1 run, 2 done, 3 err
    int          m_st   [2];
    int          m_cnt  [2];
    bit          m_we   [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_data [2];
    int          depth  [2] = '{256, 4};
    logic [31:0] base   [2] = '{32'h0, 32'h1000};
    int          OPS    [13] = '{0, 0, 0, 0, 0, 8, 35, 43, 4, 5, 2, 3, 0};
    int          FUNCTS [5]  = '{32, 34, 36, 37, 42};

    always #5 clk = ~clk;

    instr_encoder dut_a (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .valid_i(valid), .ready_o(ready_a),
        .kind_i(kind), .rs_i(rs), .rt_i(rt), .rd_i(rd), .imm_i(imm), .target_i(tgt),
        .last_i(last), .imem_we_o(we_a), .imem_addr_o(addr_a), .imem_data_o(data_a),
        .count_o(cnt_a), .done_o(done_a), .err_o(err_a)
    );

    instr_encoder #(.ADDR_W(2), .BASE_ADDR(32'h1000)) dut_b (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .valid_i(valid), .ready_o(ready_b),
        .kind_i(kind), .rs_i(rs), .rt_i(rt), .rd_i(rd), .imm_i(imm), .target_i(tgt),
        .last_i(last), .imem_we_o(we_b), .imem_addr_o(addr_b), .imem_data_o(data_b),
        .count_o(cnt_b), .done_o(done_b), .err_o(err_b)
    );

    function automatic logic [31:0] enc(input int k, input int r_s, input int r_t,
                                        input int r_d, input longint im, input longint tg);
        longint w;
        if (k <= 4)       w = r_s * 64'd2097152 + r_t * 64'd65536 + r_d * 64'd2048 + FUNCTS[k];
        else if (k <= 9)  w = OPS[k] * 64'd67108864 + r_s * 64'd2097152 + r_t * 64'd65536 + im;
        else if (k <= 11) w = OPS[k] * 64'd67108864 + tg;
        else              w = 0;
        return w[31:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_st[i] = 0; m_cnt[i] = 0; m_we[i] = 1'b0; m_addr[i] = 32'h0; m_data[i] = 32'h0;
        end
    endtask

    function automatic bit model_ready(input int i);
        return (m_st[i] == 1) && !start && (m_cnt[i] < depth[i]);
    endfunction

    task automatic model_step(input int i, input bit rdy);
        m_we[i] = 1'b0;
        if (start) begin
            m_st[i] = 1; m_cnt[i] = 0;
        end else if (valid && rdy) begin
            if (int'(kind) > 12) begin
                m_st[i] = 3;
            end else begin
                m_we[i]   = 1'b1;
                m_addr[i] = base[i] + 32'(4 * m_cnt[i]);
                m_data[i] = enc(int'(kind), int'(rs), int'(rt), int'(rd), longint'(imm), longint'(tgt));
                m_cnt[i]++;
                if (last) m_st[i] = 2;
                else if (m_cnt[i] == depth[i]) m_st[i] = 3;
            end
        end
    endtask

    task automatic check_all();
        chk("we_a",   32'(we_a),   32'(m_we[0]));
        chk("addr_a", addr_a,      m_addr[0]);
        chk("data_a", data_a,      m_data[0]);
        chk("cnt_a",  32'(cnt_a),  32'(m_cnt[0]));
        chk("done_a", 32'(done_a), 32'(m_st[0] == 2));
        chk("err_a",  32'(err_a),  32'(m_st[0] == 3));
        chk("we_b",   32'(we_b),   32'(m_we[1]));
        chk("addr_b", addr_b,      m_addr[1]);
        chk("data_b", data_b,      m_data[1]);
        chk("cnt_b",  32'(cnt_b),  32'(m_cnt[1]));
        chk("done_b", 32'(done_b), 32'(m_st[1] == 2));
        chk("err_b",  32'(err_b),  32'(m_st[1] == 3));
    endtask

    // inputs are set just after an edge; ready is checked mid-cycle, outputs #1 after the edge
    task automatic cycle();
        bit rdy [2];
        #1;
        for (int i = 0; i < 2; i++) rdy[i] = model_ready(i);
        chk("ready_a", 32'(ready_a), 32'(rdy[0]));
        chk("ready_b", 32'(ready_b), 32'(rdy[1]));
        for (int i = 0; i < 2; i++) model_step(i, rdy[i]);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic set_desc(input int k, input int r_s, input int r_t, input int r_d,
                            input int im, input int tg, input bit lst);
        valid = 1'b1; kind = 4'(k); rs = 5'(r_s); rt = 5'(r_t); rd = 5'(r_d);
        imm = 16'(im); tgt = 26'(tg); last = lst;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; valid = 1'b0; last = 1'b0;
        kind = '0; rs = '0; rt = '0; rd = '0; imm = '0; tgt = '0;
        model_reset();
        #12;
        check_all();
        chk("reset_ready_a", 32'(ready_a), 32'h0);
        chk("reset_ready_b", 32'(ready_b), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single ADD with last
        start = 1'b1; cycle();
        start = 1'b0; set_desc(0, 1, 2, 3, 0, 0, 1); cycle();
        chk("t1_we", 32'(we_a), 32'h1);
        chk("t1_data", data_a, 32'h00221820);
        chk("t1_addr", addr_a, 32'h0);
        chk("t1_cnt", 32'(cnt_a), 32'h1);
        chk("t1_done", 32'(done_a), 32'h1);
        valid = 1'b0; cycle();

        // back-to-back stream
        start = 1'b1; cycle();
        start = 1'b0;
        set_desc(5, 1, 2, 0, 5, 0, 0);            cycle();
        chk("t2_d0", data_a, 32'h20220005); chk("t2_a0", addr_a, 32'h0);
        set_desc(6, 0, 4, 0, 8, 0, 0);            cycle();
        chk("t2_d1", data_a, 32'h8C040008); chk("t2_a1", addr_a, 32'h4);
        set_desc(8, 1, 2, 0, 16'hFFFF, 0, 0);     cycle();
        chk("t2_d2", data_a, 32'h1022FFFF); chk("t2_a2", addr_a, 32'h8);
        set_desc(10, 0, 0, 0, 0, 26'h10, 1);      cycle();
        chk("t2_d3", data_a, 32'h08000010); chk("t2_a3", addr_a, 32'hC);
        chk("t2_done", 32'(done_a), 32'h1);
        valid = 1'b0; cycle();
        chk("t2_we_off", 32'(we_a), 32'h0);

        // illegal kind, then recovery
        start = 1'b1; cycle();
        start = 1'b0; set_desc(14, 1, 1, 1, 1, 1, 0); cycle();
        chk("t3_we", 32'(we_a), 32'h0);
        chk("t3_err", 32'(err_a), 32'h1);
        #1 chk("t3_ready", 32'(ready_a), 32'h0);
        valid = 1'b0; start = 1'b1; cycle();
        start = 1'b0;
        chk("t3_cnt", 32'(cnt_a), 32'h0);
        set_desc(1, 3, 4, 5, 0, 0, 0); cycle();

        // overflow on the 4-word instance
        start = 1'b1; valid = 1'b0; cycle();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_desc(1, i, i + 1, i + 2, 0, 0, 0); cycle();
        end
        chk("t4_err_b", 32'(err_b), 32'h1);
        chk("t4_cnt_b", 32'(cnt_b), 32'h4);
        chk("t4_addr_b", addr_b, 32'h100C);
        #1 chk("t4_ready_b", 32'(ready_b), 32'h0);

        // start pulsed mid-stream with valid held
        start = 1'b1; valid = 1'b0; cycle();
        start = 1'b0; set_desc(3, 7, 8, 9, 0, 0, 0); cycle(); cycle();
        start = 1'b1;
        #1 chk("t5_ready", 32'(ready_a), 32'h0);
        chk("t5_pending_we", 32'(we_a), 32'h1);
        cycle();
        start = 1'b0; cycle();
        chk("t5_we", 32'(we_a), 32'h1);
        chk("t5_addr_a", addr_a, 32'h0);
        chk("t5_addr_b", addr_b, 32'h1000);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            start = ($urandom_range(0, 29) == 0);
            valid = ($urandom_range(0, 3) != 0);
            kind  = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(13, 15)) : 4'($urandom_range(0, 12));
            rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
            imm = 16'($urandom); tgt = 26'($urandom);
            last = ($urandom_range(0, 15) == 0);
            cycle();
        end

        // asynchronous reset mid-stream
        start = 1'b1; valid = 1'b0; cycle();
        start = 1'b0; set_desc(0, 1, 2, 3, 0, 0, 0); cycle(); cycle();
        #2 rst_n = 1'b0;
        #1;
        chk("t7_we", 32'(we_a), 32'h0);
        chk("t7_cnt", 32'(cnt_a), 32'h0);
        chk("t7_done", 32'(done_a), 32'h0);
        chk("t7_err", 32'(err_a), 32'h0);
        chk("t7_cnt_b", 32'(cnt_b), 32'h0);
        model_reset();
        check_all();
        valid = 1'b0;
        rst_n = 1'b1;
        cycle();
        start = 1'b1; cycle();
        start = 1'b0; set_desc(11, 0, 0, 0, 0, 26'h3FFFFFF, 1); cycle();
        chk("t7_jal", data_a, 32'h0FFFFFFF);
        valid = 1'b0; cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
